// File: rtl/goa_pkg.sv
// Shared constants for the GOA I/O sequencer: opcodes, FSM states, default widths.
package goa_pkg;

   localparam int unsigned DATA_W_DEF     = 8;
   localparam int unsigned ADDR_W_DEF     = 4;
   localparam int unsigned WDOG_LIMIT_DEF = 1023;
   localparam int unsigned ITER_W         = 5;

   localparam logic [3:0] OP_NOP   = 4'h0;
   localparam logic [3:0] OP_WRITE = 4'h1;
   localparam logic [3:0] OP_RUN   = 4'h2;
   localparam logic [3:0] OP_READ  = 4'h3;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_WDATA  = 3'd1,
      ST_CFGWR  = 3'd2,
      ST_START  = 3'd3,
      ST_WAIT   = 3'd4,
      ST_RDADDR = 3'd5,
      ST_OUT    = 3'd6
   } state_t;

   // RUN operand 0 encodes the maximum of 16 iterations
   function automatic logic [ITER_W-1:0] iter_count(input logic [3:0] operand);
      return (operand == 4'd0) ? ITER_W'(16) : ITER_W'(operand);
   endfunction

endpackage

// File: rtl/goa_wdog_counter.sv
// Per-iteration watchdog: counts enabled cycles and flags when LIMIT is reached.
module goa_wdog_counter #(
   parameter int unsigned LIMIT = 1023
) (
   input  logic clk,
   input  logic rst,
   input  logic clear,
   input  logic enable,
   output logic expired
);

   localparam int unsigned CW = $clog2(LIMIT + 1);

   logic [CW-1:0] cnt;

   // Saturates at LIMIT so expired stays asserted until the next clear
   always_ff @(posedge clk) begin
      if (rst || clear) begin
         cnt     <= '0;
         expired <= 1'b0;
      end else if (enable && (cnt != CW'(LIMIT))) begin
         cnt     <= cnt + CW'(1);
         expired <= ((cnt + CW'(1)) == CW'(LIMIT));
      end
   end

endmodule

// File: rtl/goa_io_sequencer.sv
// Host-command sequencer: decodes byte commands into engine config writes,
// watchdog-guarded engine runs and result-register reads.
module goa_io_sequencer
   import goa_pkg::*;
#(
   parameter int unsigned DATA_W     = DATA_W_DEF,
   parameter int unsigned ADDR_W     = ADDR_W_DEF,
   parameter int unsigned WDOG_LIMIT = WDOG_LIMIT_DEF
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [DATA_W-1:0] cmd_in,
   input  logic              cmd_valid,
   output logic              cmd_ready,
   output logic [ADDR_W-1:0] cfg_addr,
   output logic [DATA_W-1:0] cfg_data,
   output logic              cfg_we,
   output logic              eng_start,
   input  logic              eng_done,
   output logic [ADDR_W-1:0] res_addr,
   input  logic [DATA_W-1:0] res_data,
   output logic [DATA_W-1:0] dout,
   output logic              dout_valid,
   input  logic              dout_ack,
   output logic              run_done,
   output logic              err,
   output logic [2:0]        state_dbg
);

   state_t            state;
   logic [ITER_W-1:0] iter_left;
   logic              wdog_expired;
   logic              accept;
   logic [3:0]        opcode;
   logic [3:0]        operand;

   assign accept    = cmd_valid && cmd_ready;
   assign opcode    = cmd_in[7:4];
   assign operand   = cmd_in[3:0];
   assign state_dbg = state;

   goa_wdog_counter #(
      .LIMIT (WDOG_LIMIT)
   ) u_wdog (
      .clk     (clk),
      .rst     (rst),
      .clear   (state == ST_START),
      .enable  (state == ST_WAIT),
      .expired (wdog_expired)
   );

   // Strobes default low each cycle; cmd_ready tracks entry into IDLE/WDATA
   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= ST_IDLE;
         cmd_ready  <= 1'b1;
         cfg_addr   <= '0;
         cfg_data   <= '0;
         cfg_we     <= 1'b0;
         eng_start  <= 1'b0;
         res_addr   <= '0;
         dout       <= '0;
         dout_valid <= 1'b0;
         run_done   <= 1'b0;
         err        <= 1'b0;
         iter_left  <= '0;
      end else begin
         cfg_we    <= 1'b0;
         eng_start <= 1'b0;
         run_done  <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (accept) begin
                  case (opcode)
                     OP_NOP: begin
                        if (operand == 4'd0) err <= 1'b0;
                     end
                     OP_WRITE: begin
                        cfg_addr <= ADDR_W'(operand);
                        state    <= ST_WDATA;
                     end
                     OP_RUN: begin
                        iter_left <= iter_count(operand);
                        eng_start <= 1'b1;
                        cmd_ready <= 1'b0;
                        state     <= ST_START;
                     end
                     OP_READ: begin
                        res_addr  <= ADDR_W'(operand);
                        cmd_ready <= 1'b0;
                        state     <= ST_RDADDR;
                     end
                     default: err <= 1'b1;
                  endcase
               end
            end
            ST_WDATA: begin
               if (accept) begin
                  cfg_data  <= cmd_in;
                  cfg_we    <= 1'b1;
                  cmd_ready <= 1'b0;
                  state     <= ST_CFGWR;
               end
            end
            ST_CFGWR: begin
               cmd_ready <= 1'b1;
               state     <= ST_IDLE;
            end
            ST_START: begin
               state <= ST_WAIT;
            end
            ST_WAIT: begin
               if (eng_done) begin
                  if (iter_left == ITER_W'(1)) begin
                     iter_left <= '0;
                     run_done  <= 1'b1;
                     cmd_ready <= 1'b1;
                     state     <= ST_IDLE;
                  end else begin
                     iter_left <= iter_left - ITER_W'(1);
                     eng_start <= 1'b1;
                     state     <= ST_START;
                  end
               end else if (wdog_expired) begin
                  err       <= 1'b1;
                  iter_left <= '0;
                  cmd_ready <= 1'b1;
                  state     <= ST_IDLE;
               end
            end
            ST_RDADDR: begin
               dout       <= res_data;
               dout_valid <= 1'b1;
               state      <= ST_OUT;
            end
            ST_OUT: begin
               if (dout_ack) begin
                  dout_valid <= 1'b0;
                  cmd_ready  <= 1'b1;
                  state      <= ST_IDLE;
               end
            end
            default: begin
               cmd_ready <= 1'b1;
               state     <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_goa_io_sequencer.sv
// Scoreboard bench for goa_io_sequencer: stimulus queues expected strobes,
// a negedge monitor pops and compares them as the DUT produces them.
module tb_goa_io_sequencer;
   import goa_pkg::*;

   localparam int unsigned LIMIT = 1023;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [7:0] cmd_in = 8'h00;
   logic       cmd_valid = 1'b0;
   logic       cmd_ready;
   logic [3:0] cfg_addr;
   logic [7:0] cfg_data;
   logic       cfg_we;
   logic       eng_start;
   logic       eng_done = 1'b0;
   logic [3:0] res_addr;
   logic [7:0] res_data;
   logic [7:0] dout;
   logic       dout_valid;
   logic       dout_ack = 1'b0;
   logic       run_done;
   logic       err;
   logic [2:0] state_dbg;

   logic [7:0] res_mem [16];
   int         done_delay = 0;
   int         tests = 0;
   int         fails = 0;

   typedef enum int {EV_CFG, EV_START, EV_DONE, EV_DOUT} ev_kind_t;
   typedef struct {
      ev_kind_t   kind;
      logic [3:0] addr;
      logic [7:0] data;
   } ev_t;
   ev_t exp_q[$];

   always #5 clk = ~clk;

   assign res_data = res_mem[res_addr];

   goa_io_sequencer #(
      .DATA_W     (8),
      .ADDR_W     (4),
      .WDOG_LIMIT (LIMIT)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .cmd_in     (cmd_in),
      .cmd_valid  (cmd_valid),
      .cmd_ready  (cmd_ready),
      .cfg_addr   (cfg_addr),
      .cfg_data   (cfg_data),
      .cfg_we     (cfg_we),
      .eng_start  (eng_start),
      .eng_done   (eng_done),
      .res_addr   (res_addr),
      .res_data   (res_data),
      .dout       (dout),
      .dout_valid (dout_valid),
      .dout_ack   (dout_ack),
      .run_done   (run_done),
      .err        (err),
      .state_dbg  (state_dbg)
   );

   function automatic void push(input ev_kind_t k, input logic [3:0] a, input logic [7:0] d);
      ev_t e;
      e.kind = k;
      e.addr = a;
      e.data = d;
      exp_q.push_back(e);
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic expect_event(input ev_kind_t k, input logic [3:0] a, input logic [7:0] d);
      ev_t e;
      tests++;
      if (exp_q.size() == 0) begin
         fails++;
         $display("FAIL sb_unexpected: event kind %0d addr 0x%0h data 0x%0h, none expected",
                  int'(k), a, d);
      end else begin
         e = exp_q.pop_front();
         if (e.kind != k || e.addr !== a || e.data !== d) begin
            fails++;
            $display("FAIL sb_event: got kind %0d addr 0x%0h data 0x%0h, expected kind %0d addr 0x%0h data 0x%0h",
                     int'(k), a, d, int'(e.kind), e.addr, e.data);
         end
      end
   endtask

   // Monitor: every strobe and every new dout byte is matched against the queue
   initial begin
      logic prev_dv;
      prev_dv = 1'b0;
      forever begin
         @(negedge clk);
         if (cfg_we === 1'b1) expect_event(EV_CFG, cfg_addr, cfg_data);
         if (eng_start === 1'b1) expect_event(EV_START, 4'h0, 8'h00);
         if (run_done === 1'b1) expect_event(EV_DONE, 4'h0, 8'h00);
         if (dout_valid === 1'b1 && !prev_dv) expect_event(EV_DOUT, 4'h0, dout);
         prev_dv = (dout_valid === 1'b1);
      end
   end

   // Engine model: eng_done pulses done_delay cycles after each start (0 = never)
   initial begin
      forever begin
         @(posedge clk);
         #1;
         while (eng_start === 1'b1 && done_delay > 0) begin
            repeat (done_delay) @(posedge clk);
            #1 eng_done = 1'b1;
            @(posedge clk);
            #1 eng_done = 1'b0;
         end
      end
   end

   task automatic send(input logic [7:0] b);
      int n;
      n = 0;
      @(negedge clk);
      cmd_in    = b;
      cmd_valid = 1'b1;
      while (cmd_ready !== 1'b1 && n < 100) begin
         @(negedge clk);
         n++;
      end
      if (cmd_ready !== 1'b1) begin
         tests++;
         fails++;
         $display("FAIL send_timeout: byte 0x%0h not accepted, cmd_ready=%b expected 1", b, cmd_ready);
         cmd_valid = 1'b0;
      end else begin
         @(posedge clk);
         #1 cmd_valid = 1'b0;
      end
   endtask

   task automatic check_reset_values(input string tag);
      check({tag, "_ready"},     32'(cmd_ready),  32'd1);
      check({tag, "_cfg_we"},    32'(cfg_we),     32'd0);
      check({tag, "_eng_start"}, 32'(eng_start),  32'd0);
      check({tag, "_run_done"},  32'(run_done),   32'd0);
      check({tag, "_dout_vld"},  32'(dout_valid), 32'd0);
      check({tag, "_err"},       32'(err),        32'd0);
      check({tag, "_cfg_addr"},  32'(cfg_addr),   32'd0);
      check({tag, "_cfg_data"},  32'(cfg_data),   32'd0);
      check({tag, "_res_addr"},  32'(res_addr),   32'd0);
      check({tag, "_dout"},      32'(dout),       32'd0);
      check({tag, "_state"},     32'(state_dbg),  32'(ST_IDLE));
   endtask

   initial begin
      int bad;
      int n;
      int wait_n;
      for (int i = 0; i < 16; i++) res_mem[i] = 8'(i * 17);
      res_mem[12] = 8'h5A;

      rst = 1'b1;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      check_reset_values("reset");

      // WRITE 0x15, 0xA7
      push(EV_CFG, 4'h5, 8'hA7);
      send(8'h15);
      check("wdata_state", 32'(state_dbg), 32'(ST_WDATA));
      send(8'hA7);
      check("cfg_we_latency", 32'(cfg_we), 32'd1);
      repeat (3) @(negedge clk);

      // RUN 3 iterations, done 4 cycles after each start
      done_delay = 4;
      push(EV_START, 4'h0, 8'h00);
      push(EV_START, 4'h0, 8'h00);
      push(EV_START, 4'h0, 8'h00);
      push(EV_DONE, 4'h0, 8'h00);
      send(8'h23);
      check("eng_start_latency", 32'(eng_start), 32'd1);
      bad = 0;
      n = 0;
      while (n < 200) begin
         @(negedge clk);
         n++;
         if (run_done === 1'b1) break;
         if (cmd_ready !== 1'b0) bad++;
      end
      check("run3_done_seen", 32'(run_done), 32'd1);
      check("run3_ready_low", 32'(bad), 32'd0);
      @(negedge clk);
      check("run3_idle", 32'(state_dbg), 32'(ST_IDLE));

      // READ address 12, ack held off for 10 cycles
      push(EV_DOUT, 4'h0, 8'h5A);
      send(8'h3C);
      n = 0;
      while (dout_valid !== 1'b1 && n < 20) begin
         @(negedge clk);
         n++;
      end
      check("read_valid", 32'(dout_valid), 32'd1);
      bad = 0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         if (dout !== 8'h5A || dout_valid !== 1'b1 || cmd_ready !== 1'b0) bad++;
      end
      check("read_hold", 32'(bad), 32'd0);
      dout_ack = 1'b1;
      @(posedge clk);
      #1 dout_ack = 1'b0;
      check("ack_valid_clr", 32'(dout_valid), 32'd0);
      check("ack_ready", 32'(cmd_ready), 32'd1);
      check("ack_idle", 32'(state_dbg), 32'(ST_IDLE));

      // Stray ack while nothing is pending
      @(negedge clk);
      dout_ack = 1'b1;
      @(negedge clk);
      dout_ack = 1'b0;
      check("stray_ack_state", 32'(state_dbg), 32'(ST_IDLE));
      check("stray_ack_dout", 32'({dout_valid, dout}), 32'h05A);

      // RUN 1 with the engine silent: watchdog abort
      done_delay = 0;
      push(EV_START, 4'h0, 8'h00);
      send(8'h21);
      wait_n = 0;
      n = 0;
      while (err !== 1'b1 && n < 1200) begin
         @(negedge clk);
         n++;
         if (state_dbg === 3'(ST_WAIT)) wait_n++;
      end
      check("wdog_err", 32'(err), 32'd1);
      check("wdog_idle", 32'(state_dbg), 32'(ST_IDLE));
      check("wdog_ready", 32'(cmd_ready), 32'd1);
      check("wdog_window", 32'(wait_n >= int'(LIMIT) && wait_n <= int'(LIMIT) + 2), 32'd1);
      send(8'h05);
      check("nop_nonzero_keeps_err", 32'(err), 32'd1);
      send(8'h00);
      check("nop_clears_err", 32'(err), 32'd0);

      // Illegal opcode
      send(8'h9F);
      check("bad_op_err", 32'(err), 32'd1);
      check("bad_op_state", 32'(state_dbg), 32'(ST_IDLE));
      send(8'h00);
      check("bad_op_cleared", 32'(err), 32'd0);

      // RUN 16 interrupted by reset in WAIT
      push(EV_START, 4'h0, 8'h00);
      send(8'h20);
      repeat (5) @(negedge clk);
      check("rst_run_in_wait", 32'(state_dbg), 32'(ST_WAIT));
      rst = 1'b1;
      @(negedge clk);
      check_reset_values("midrun_rst");
      rst = 1'b0;

      // Recovery: WRITE to the top address after reset
      push(EV_CFG, 4'hF, 8'h3C);
      send(8'h1F);
      send(8'h3C);
      repeat (20) @(negedge clk);

      check("sb_drained", 32'(exp_q.size()), 32'd0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
